// File: rtl/window_3x3_gen_pkg.sv
// Shared pixel definitions for the dehaze pipeline (window generator,
// atmospheric-light estimator and later stages).
package window_3x3_gen_pkg;

   localparam int PIX_W = 24;

   // Channel slices inside a packed RGB pixel.
   localparam int R_HI = 23;
   localparam int R_LO = 16;
   localparam int G_HI = 15;
   localparam int G_LO = 8;
   localparam int B_HI = 7;
   localparam int B_LO = 0;

   typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-stream in / 3x3 window out bundle. The master drives the raster
// stream and observes the window; the slave is the window generator.
interface window_3x3_gen_if;
   import window_3x3_gen_pkg::*;

   logic   i_valid;
   logic   i_sof;
   pixel_t i_pixel;

   pixel_t output_pixel_1;
   pixel_t output_pixel_2;
   pixel_t output_pixel_3;
   pixel_t output_pixel_4;
   pixel_t output_pixel_5;
   pixel_t output_pixel_6;
   pixel_t output_pixel_7;
   pixel_t output_pixel_8;
   pixel_t output_pixel_9;
   logic   o_valid;

   modport master (
      output i_valid, i_sof, i_pixel,
      input  output_pixel_1, output_pixel_2, output_pixel_3,
      input  output_pixel_4, output_pixel_5, output_pixel_6,
      input  output_pixel_7, output_pixel_8, output_pixel_9,
      input  o_valid
   );

   modport slave (
      input  i_valid, i_sof, i_pixel,
      output output_pixel_1, output_pixel_2, output_pixel_3,
      output output_pixel_4, output_pixel_5, output_pixel_6,
      output output_pixel_7, output_pixel_8, output_pixel_9,
      output o_valid
   );

endinterface

// File: rtl/window_3x3_gen_line_buffer_ram.sv
// One row of pixel storage. Single port: the read at addr returns the
// contents from before this cycle's write, so a shift-through of one row
// happens in the same cycle the new pixel is stored.
module window_3x3_gen_line_buffer_ram
   import window_3x3_gen_pkg::*;
#(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  pixel_t            wr_data,
   output pixel_t            rd_data
);

   pixel_t mem_r [DEPTH];

   assign rd_data = mem_r[addr];

   // Store the incoming pixel; contents are never reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator. Two line buffers supply the two
// rows above the incoming pixel; a 3x3 register window shifts left on each
// accepted pixel and is flagged valid only when it lies fully in the frame.
module window_3x3_gen
   import window_3x3_gen_pkg::*;
#(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512
) (
   input logic             clk,
   input logic             rst,
   window_3x3_gen_if.slave bus
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   logic [COL_W-1:0] col_r;
   logic [ROW_W-1:0] row_r;
   logic [COL_W-1:0] col_s;
   logic [ROW_W-1:0] row_s;
   logic [COL_W-1:0] col_next_s;
   logic [ROW_W-1:0] row_next_s;

   logic   lb_we_s;
   pixel_t top_tap_s;
   pixel_t mid_tap_s;

   pixel_t win_r [3][3];
   logic   o_valid_r;

   // Position of the pixel on the input; i_sof pins it to the frame origin.
   always_comb begin
      col_s = col_r;
      row_s = row_r;
      if (bus.i_sof) begin
         col_s = {COL_W{1'b0}};
         row_s = {ROW_W{1'b0}};
      end else begin
         col_s = col_r;
         row_s = row_r;
      end
   end

   // Raster advance with wrap at end of row and end of frame.
   always_comb begin
      col_next_s = col_s;
      row_next_s = row_s;
      if (col_s == COL_LAST) begin
         col_next_s = {COL_W{1'b0}};
         if (row_s == ROW_LAST) begin
            row_next_s = {ROW_W{1'b0}};
         end else begin
            row_next_s = row_s + ROW_W'(1);
         end
      end else begin
         col_next_s = col_s + COL_W'(1);
         row_next_s = row_s;
      end
   end

   // A pixel arriving together with rst is dropped entirely.
   assign lb_we_s = bus.i_valid & ~rst;

   window_3x3_gen_line_buffer_ram #(
      .DEPTH  (IMG_WIDTH),
      .ADDR_W (COL_W)
   ) lb0 (
      .clk     (clk),
      .we      (lb_we_s),
      .addr    (col_s),
      .wr_data (bus.i_pixel),
      .rd_data (mid_tap_s)
   );

   window_3x3_gen_line_buffer_ram #(
      .DEPTH  (IMG_WIDTH),
      .ADDR_W (COL_W)
   ) lb1 (
      .clk     (clk),
      .we      (lb_we_s),
      .addr    (col_s),
      .wr_data (mid_tap_s),
      .rd_data (top_tap_s)
   );

   // Counters, window shift and validity flag, all advancing on accepted pixels.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_r     <= {COL_W{1'b0}};
         row_r     <= {ROW_W{1'b0}};
         o_valid_r <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_r[r][c] <= {PIX_W{1'b0}};
            end
         end
      end else if (bus.i_valid) begin
         col_r     <= col_next_s;
         row_r     <= row_next_s;
         // Column >= 2 also rejects windows straddling a row wrap.
         o_valid_r <= (row_s >= ROW_TWO) && (col_s >= COL_TWO);
         for (int r = 0; r < 3; r++) begin
            win_r[r][0] <= win_r[r][1];
            win_r[r][1] <= win_r[r][2];
         end
         win_r[0][2] <= top_tap_s;
         win_r[1][2] <= mid_tap_s;
         win_r[2][2] <= bus.i_pixel;
      end else begin
         o_valid_r <= 1'b0;
      end
   end

   assign bus.output_pixel_1 = win_r[0][0];
   assign bus.output_pixel_2 = win_r[0][1];
   assign bus.output_pixel_3 = win_r[0][2];
   assign bus.output_pixel_4 = win_r[1][0];
   assign bus.output_pixel_5 = win_r[1][1];
   assign bus.output_pixel_6 = win_r[1][2];
   assign bus.output_pixel_7 = win_r[2][0];
   assign bus.output_pixel_8 = win_r[2][1];
   assign bus.output_pixel_9 = win_r[2][2];
   assign bus.o_valid        = o_valid_r;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen on an 8x6 frame. Pixels carry
// their own coordinates ({row, col, tag}), so every expected window is
// built from the bench's own raster position model.
module tb_window_3x3_gen;
   import window_3x3_gen_pkg::*;

   localparam int W = 8;
   localparam int H = 6;
   localparam int WIN_PER_FRAME = (W - 2) * (H - 2);
   localparam int FIRST_VALID = 2 * W + 3;

   typedef logic [8:0][PIX_W-1:0] win_t;

   logic clk = 1'b0;
   logic rst;

   window_3x3_gen_if bus ();

   window_3x3_gen #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   win_t       exp_q [$];
   int         mrow = 0;
   int         mcol = 0;
   logic [7:0] mtag = 8'hA5;

   function automatic win_t dut_win();
      win_t w;
      w[0] = bus.output_pixel_1;
      w[1] = bus.output_pixel_2;
      w[2] = bus.output_pixel_3;
      w[3] = bus.output_pixel_4;
      w[4] = bus.output_pixel_5;
      w[5] = bus.output_pixel_6;
      w[6] = bus.output_pixel_7;
      w[7] = bus.output_pixel_8;
      w[8] = bus.output_pixel_9;
      return w;
   endfunction

   // Window whose bottom-right pixel is (r,c) of the current frame.
   function automatic win_t model_win(input int r, input int c);
      win_t w;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            w[i*3+j] = {8'(r - 2 + i), 8'(c - 2 + j), mtag};
         end
      end
      return w;
   endfunction

   // Drive one accepted pixel, record the expected window, advance the model.
   task automatic send(input logic sof);
      if (sof) begin
         mrow = 0;
         mcol = 0;
      end
      if (mrow >= 2 && mcol >= 2) exp_q.push_back(model_win(mrow, mcol));
      bus.i_valid = 1'b1;
      bus.i_sof   = sof;
      bus.i_pixel = {8'(mrow), 8'(mcol), mtag};
      if (mcol == W - 1) begin
         mcol = 0;
         mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end else begin
         mcol = mcol + 1;
      end
      @(posedge clk);
      #1;
   endtask

   // One idle cycle with junk on the data and sof lines.
   task automatic idle();
      bus.i_valid = 1'b0;
      bus.i_sof   = 1'($urandom_range(0, 1));
      bus.i_pixel = 24'($urandom);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.i_valid = 1'b1;
      bus.i_sof   = 1'b0;
      bus.i_pixel = 24'h123456;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b expected 0", bus.o_valid);
      end
      checks++;
      if (dut_win() !== '0) begin
         errors++;
         $display("FAIL reset_window: got %h expected all zero", dut_win());
      end
      rst = 1'b0;
      bus.i_valid = 1'b0;
      mrow = 0;
      mcol = 0;
   endtask

   task automatic test_single_frame();
      win_t exp_w;
      win_t first_w;
      int   nvalid = 0;
      int   first_idx = 0;
      mtag = 8'hA5;
      for (int k = 0; k < W * H; k++) begin
         send(k == 0);
         if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (bus.o_valid !== 1'b1 || dut_win() !== exp_w) begin
               errors++;
               $display("FAIL single_window: valid=%b got %h expected %h", bus.o_valid, dut_win(), exp_w);
            end
         end else begin
            checks++;
            if (bus.o_valid !== 1'b0) begin
               errors++;
               $display("FAIL single_spurious_valid: got %b expected 0 at pixel %0d", bus.o_valid, k);
            end
         end
         if (bus.o_valid === 1'b1) begin
            nvalid++;
            if (first_idx == 0) begin
               first_idx = k + 1;
               first_w   = dut_win();
            end
         end
      end
      checks++;
      if (first_idx != FIRST_VALID) begin
         errors++;
         $display("FAIL first_valid_latency: got pixel %0d expected %0d", first_idx, FIRST_VALID);
      end
      checks++;
      if (first_w[0] !== 24'h0000A5) begin
         errors++;
         $display("FAIL first_pixel_1: got %h expected 0000a5", first_w[0]);
      end
      checks++;
      if (first_w[4] !== 24'h0101A5) begin
         errors++;
         $display("FAIL first_pixel_5: got %h expected 0101a5", first_w[4]);
      end
      checks++;
      if (first_w[8] !== 24'h0202A5) begin
         errors++;
         $display("FAIL first_pixel_9: got %h expected 0202a5", first_w[8]);
      end
      checks++;
      if (nvalid != WIN_PER_FRAME) begin
         errors++;
         $display("FAIL single_count: got %0d expected %0d", nvalid, WIN_PER_FRAME);
      end
   endtask

   task automatic test_gaps();
      win_t exp_w;
      win_t held;
      int   sent = 0;
      int   nvalid = 0;
      int   cyc = 0;
      mtag = 8'hA5;
      while (sent < W * H && cyc < 2000) begin
         cyc++;
         if (sent > 0 && $urandom_range(0, 9) < 4) begin
            held = dut_win();
            idle();
            checks++;
            if (bus.o_valid !== 1'b0 || dut_win() !== held) begin
               errors++;
               $display("FAIL gap_hold: valid=%b got %h expected %h", bus.o_valid, dut_win(), held);
            end
         end else begin
            send(sent == 0);
            sent++;
            if (exp_q.size() != 0) begin
               exp_w = exp_q.pop_front();
               checks++;
               if (bus.o_valid !== 1'b1 || dut_win() !== exp_w) begin
                  errors++;
                  $display("FAIL gap_window: valid=%b got %h expected %h", bus.o_valid, dut_win(), exp_w);
               end
            end else begin
               checks++;
               if (bus.o_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL gap_spurious_valid: got %b expected 0", bus.o_valid);
               end
            end
            if (bus.o_valid === 1'b1) nvalid++;
         end
      end
      checks++;
      if (nvalid != WIN_PER_FRAME) begin
         errors++;
         $display("FAIL gap_count: got %0d expected %0d", nvalid, WIN_PER_FRAME);
      end
   endtask

   // Second frame follows without i_sof, relying on the end-of-frame wrap.
   task automatic test_back_to_back();
      win_t exp_w;
      win_t w;
      int   nvalid = 0;
      int   n_old = 0;
      for (int k = 0; k < 2 * W * H; k++) begin
         mtag = (k < W * H) ? 8'hA5 : 8'h5A;
         send(k == 0);
         if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (bus.o_valid !== 1'b1 || dut_win() !== exp_w) begin
               errors++;
               $display("FAIL b2b_window: valid=%b got %h expected %h", bus.o_valid, dut_win(), exp_w);
            end
         end else begin
            checks++;
            if (bus.o_valid !== 1'b0) begin
               errors++;
               $display("FAIL b2b_spurious_valid: got %b expected 0", bus.o_valid);
            end
         end
         if (k >= W * H && bus.o_valid === 1'b1) begin
            nvalid++;
            w = dut_win();
            for (int t = 0; t < 9; t++) begin
               if (w[t][7:0] == 8'hA5) n_old++;
            end
         end
      end
      checks++;
      if (nvalid != WIN_PER_FRAME) begin
         errors++;
         $display("FAIL b2b_count: got %0d expected %0d", nvalid, WIN_PER_FRAME);
      end
      checks++;
      if (n_old != 0) begin
         errors++;
         $display("FAIL b2b_stale_data: got %0d old-frame pixels expected 0", n_old);
      end
   endtask

   task automatic test_sof_restart();
      win_t exp_w;
      int   since = 0;
      int   first_idx = 0;
      logic [PIX_W-1:0] first_p1 = '0;
      mtag = 8'hA5;
      send(1'b1);
      while (!(mrow == 3 && mcol == 4)) begin
         send(1'b0);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      mtag = 8'h3C;
      for (int k = 0; k < W * H && first_idx == 0; k++) begin
         send(k == 0);
         since++;
         if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (bus.o_valid !== 1'b1 || dut_win() !== exp_w) begin
               errors++;
               $display("FAIL restart_window: valid=%b got %h expected %h", bus.o_valid, dut_win(), exp_w);
            end
         end else begin
            checks++;
            if (bus.o_valid !== 1'b0) begin
               errors++;
               $display("FAIL restart_spurious_valid: got %b expected 0 at pixel %0d", bus.o_valid, since);
            end
         end
         if (bus.o_valid === 1'b1) begin
            first_idx = since;
            first_p1  = bus.output_pixel_1;
         end
      end
      checks++;
      if (first_idx != FIRST_VALID) begin
         errors++;
         $display("FAIL restart_latency: got pixel %0d expected %0d", first_idx, FIRST_VALID);
      end
      checks++;
      if (first_p1 !== 24'h00003C) begin
         errors++;
         $display("FAIL restart_pixel_1: got %h expected 00003c", first_p1);
      end
   endtask

   task automatic test_reset_mid_frame();
      win_t exp_w;
      int   since = 0;
      int   first_idx = 0;
      mtag = 8'h77;
      send(1'b1);
      while (!(mrow == 4 && mcol == 5)) begin
         send(1'b0);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      rst = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_sof   = 1'b0;
      bus.i_pixel = {8'd4, 8'd5, mtag};
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (bus.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_valid: got %b expected 0", bus.o_valid);
      end
      checks++;
      if (dut_win() !== '0) begin
         errors++;
         $display("FAIL midrst_window: got %h expected all zero", dut_win());
      end
      mrow = 0;
      mcol = 0;
      exp_q.delete();
      for (int k = 0; k < W * H && first_idx == 0; k++) begin
         send(1'b0);
         since++;
         if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (bus.o_valid !== 1'b1 || dut_win() !== exp_w) begin
               errors++;
               $display("FAIL midrst_window_after: valid=%b got %h expected %h", bus.o_valid, dut_win(), exp_w);
            end
         end else begin
            checks++;
            if (bus.o_valid !== 1'b0) begin
               errors++;
               $display("FAIL midrst_spurious_valid: got %b expected 0 at pixel %0d", bus.o_valid, since);
            end
         end
         if (bus.o_valid === 1'b1) first_idx = since;
      end
      checks++;
      if (first_idx != FIRST_VALID) begin
         errors++;
         $display("FAIL midrst_latency: got pixel %0d expected %0d", first_idx, FIRST_VALID);
      end
   endtask

   initial begin
      rst         = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_sof   = 1'b0;
      bus.i_pixel = 24'h000000;
      test_reset();
      test_single_frame();
      test_gaps();
      test_back_to_back();
      test_sof_restart();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
